// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 register IDs, data width and icode constants
package y86_pkg;

  localparam int W = 64;

  typedef logic [3:0] reg_id_t;

  localparam reg_id_t RRAX  = 4'd0;
  localparam reg_id_t RRCX  = 4'd1;
  localparam reg_id_t RRDX  = 4'd2;
  localparam reg_id_t RRBX  = 4'd3;
  localparam reg_id_t RRSP  = 4'd4;
  localparam reg_id_t RRBP  = 4'd5;
  localparam reg_id_t RRSI  = 4'd6;
  localparam reg_id_t RRDI  = 4'd7;
  localparam reg_id_t RR8   = 4'd8;
  localparam reg_id_t RR9   = 4'd9;
  localparam reg_id_t RR10  = 4'd10;
  localparam reg_id_t RR11  = 4'd11;
  localparam reg_id_t RR12  = 4'd12;
  localparam reg_id_t RR13  = 4'd13;
  localparam reg_id_t RR14  = 4'd14;
  localparam reg_id_t RNONE = 4'd15;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_t;

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one combinational register read port with write-back bypass
module reg_read_port #(
  parameter int         W     = y86_pkg::W,
  parameter logic [3:0] RNONE = y86_pkg::RNONE
) (
  input  logic [14:0][W-1:0] regs,
  input  logic               byp_en,
  input  logic [3:0]         src,
  input  logic [3:0]         dstE,
  input  logic [W-1:0]       valE,
  input  logic [3:0]         dstM,
  input  logic [W-1:0]       valM,
  output logic [W-1:0]       val
);

  // M is checked before E so a read agrees with the write-collision winner.
  always_comb begin
    val = '0;
    if (src != RNONE) begin
      if (byp_en && src == dstM)
        val = valM;
      else if (byp_en && src == dstE)
        val = valE;
      else
        val = regs[src];
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 15 x W Y86-64 program register file, two read ports, E/M write ports
module reg_file #(
  parameter int         W      = y86_pkg::W,
  parameter bit         BYPASS = 1'b1,
  parameter logic [3:0] RNONE  = y86_pkg::RNONE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_en,
  input  logic [3:0]   dstE,
  input  logic [W-1:0] valE,
  input  logic [3:0]   dstM,
  input  logic [W-1:0] valM,
  input  logic [3:0]   srcA,
  input  logic [3:0]   srcB,
  output logic [W-1:0] valA,
  output logic [W-1:0] valB,
  input  logic [3:0]   dbg_sel,
  output logic [W-1:0] dbg_val
);

  logic [14:0][W-1:0] regs;
  logic               byp_en;

  // M is written last so it wins a dstE == dstM collision (popq %rsp).
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (wb_en) begin
      if (dstE != RNONE) regs[dstE] <= valE;
      if (dstM != RNONE) regs[dstM] <= valM;
    end
  end

  assign byp_en = BYPASS && !rst && wb_en;

  reg_read_port #(.W(W), .RNONE(RNONE)) u_port_a (
    .regs   (regs),
    .byp_en (byp_en),
    .src    (srcA),
    .dstE   (dstE),
    .valE   (valE),
    .dstM   (dstM),
    .valM   (valM),
    .val    (valA)
  );

  reg_read_port #(.W(W), .RNONE(RNONE)) u_port_b (
    .regs   (regs),
    .byp_en (byp_en),
    .src    (srcB),
    .dstE   (dstE),
    .valE   (valE),
    .dstM   (dstM),
    .valM   (valM),
    .val    (valB)
  );

  always_comb begin
    dbg_val = '0;
    if (dbg_sel != RNONE) dbg_val = regs[dbg_sel];
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 15-entry, 64-bit Y86-64 program register file: the write target of the write-back stage and the read source for the decode stage.
- Write side accepts the dstE/valE and dstM/valM pairs produced by write-back; register ID 15 (RNONE) means no write.
- Read side serves two decode ports, srcA/valA and srcB/valB, with optional same-cycle write-to-read bypass.
- Used unchanged in SEQ; PIPE uses it with BYPASS=1.

Parameters:
- W, 64, data width of each register.
- BYPASS, 1, 1 = a write in the current cycle is visible on read ports in the same cycle; 0 = visible only from the next cycle.
- RNONE, 15, register ID meaning "no register".

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- wb_en  input  1  global write enable; low on stall, bubble or halted status.
- dstE  input  4  E-port destination register ID.
- valE  input  W  E-port write data.
- dstM  input  4  M-port destination register ID.
- valM  input  W  M-port write data.
- srcA  input  4  read port A register ID.
- srcB  input  4  read port B register ID.
- valA  output  W  read port A data.
- valB  output  W  read port B data.
- dbg_sel  input  4  debug read select for the bench.
- dbg_val  output  W  debug read data; never bypassed.

Behaviour:
- Storage: regs[0..14], each W bits. IDs: 0 rax, 1 rcx, 2 rdx, 3 rbx, 4 rsp, 5 rbp, 6 rsi, 7 rdi, 8..14 r8..r14. ID 15 has no storage.
- Reset:
  - With rst high at a rising edge, all 15 registers become 0.
  - Writes in that cycle are discarded.
  - While rst is high, bypass is disabled and reads return stored contents, so valA, valB and dbg_val read 0 one cycle after reset.
- Write, rising edge, rst low, wb_en high:
  - if dstE != 15, regs[dstE] <= valE.
  - if dstM != 15, regs[dstM] <= valM.
  - Write latency is 1 cycle.
- Write collision (dstE == dstM != 15): the M port wins and the register takes valM. This covers popq %rsp, where dstE = dstM = 4 and the result must be the popped value.
- wb_en low: no register changes, and bypass is disabled for that cycle.
- Read ports are combinational, with zero latency from srcA/srcB:
  - src == 15 returns 0.
  - BYPASS=1, rst low, wb_en high: if src == dstM != 15, return valM; else if src == dstE != 15, return valE; else return regs[src]. M has priority, matching the collision rule.
  - BYPASS=0: always return regs[src].
- srcA == srcB is legal; both ports return the same value.
- Widths: no arithmetic inside the block. Data passes through unmodified. IDs are exactly 4 bits, so there is no out-of-range case beyond 15.
- Reset mid-operation: any write in the rst cycle is lost, and contents are 0 on the next cycle regardless of earlier writes.
- No X propagation: outputs are defined for every input value once the first reset has been applied.

Decomposition:
- Shared package y86_pkg:
  - register ID constants RRAX..RR14 and RNONE=15.
  - the data-width constant W=64.
  - the icode constants already used by write-back and decode.
- One natural sub-module, reg_read_port: a combinational mux with bypass priority, instantiated twice (A and B).
- dbg_val uses a plain mux with no bypass.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then srcA=0, srcB=14 -> valA=0, valB=0; dbg over 0..14 all read 0.
- Basic E write: wb_en=1, dstE=3, valE=0x1122334455667788, dstM=15, then one edge -> dbg_sel=3 reads 0x1122334455667788. With BYPASS=1 and srcA=3 in the write cycle, valA shows the value combinationally.
- Collision: dstE=4, valE=0x100, dstM=4, valM=0xDEAD, one edge -> regs[4]=0xDEAD. In the same cycle, srcB=4 -> valB=0xDEAD.
- Dual write, different registers: dstE=1 with 0xA and dstM=2 with 0xB -> regs[1]=0xA and regs[2]=0xB. A read of srcA=15 returns 0.
- Stall: wb_en=0, dstE=5, valE=0x55 -> regs[5] unchanged (0), and srcA=5 returns 0 in the same cycle (no bypass).
- Reset mid-stream: write regs[7]=0x77, then assert rst in the same cycle as a write of dstM=7, valM=0x99 -> regs[7]=0 after the edge; valA for srcA=7 reads 0.
